// File: rtl/hood_mode_sequencer_pkg.sv
// hood_mode_sequencer_pkg
// Shared definitions for the range-hood mode sequencer: mode encodings,
// default timing and reminder constants, and a helper that says whether a
// mode runs the fan (and therefore accumulates worktime).
package hood_mode_sequencer_pkg;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_STANDBY = 3'd1;
  localparam logic [2:0] MODE_L1      = 3'd2;
  localparam logic [2:0] MODE_L2      = 3'd3;
  localparam logic [2:0] MODE_STORM   = 3'd4;
  localparam logic [2:0] MODE_CLEAN   = 3'd5;

  localparam logic [7:0] STORM_SEC_DEF    = 8'd60;
  localparam logic [7:0] CLEAN_SEC_DEF    = 8'd180;
  localparam logic [7:0] REMIND_HOURS_DEF = 8'h10;

  // Fan-running modes are the ones in which the accumulator counts.
  function automatic logic fan_running(input logic [2:0] m);
    return (m == MODE_L1) || (m == MODE_L2) || (m == MODE_STORM);
  endfunction

endpackage

// File: rtl/hood_mode_sequencer_if.sv
// hood_mode_sequencer_if
// Request/status bundle between the user-input side (master) and the mode
// sequencer (slave).
//   master drives : tick_1s, power_on, req_* pulses, worktime
//   slave  drives : mode, suspend, clean_worktime_yet, countdown,
//                   remind_clean, storm_used
// Signalling: there is no valid/ready pairing here. Every req_* and tick_1s
// is a single-cycle strobe, sampled on the rising clock edge; a strobe that
// is not legal in the current mode is dropped and never queued. power_on and
// worktime are levels. All slave outputs are registered.
interface hood_mode_sequencer_if;
  logic        tick_1s;
  logic        power_on;
  logic        req_stop;
  logic        req_l1;
  logic        req_l2;
  logic        req_storm;
  logic        req_clean;
  logic [23:0] worktime;
  logic [2:0]  mode;
  logic        suspend;
  logic        clean_worktime_yet;
  logic [7:0]  countdown;
  logic        remind_clean;
  logic        storm_used;

  modport master (
    output tick_1s, power_on, req_stop, req_l1, req_l2, req_storm, req_clean,
           worktime,
    input  mode, suspend, clean_worktime_yet, countdown, remind_clean,
           storm_used
  );

  modport slave (
    input  tick_1s, power_on, req_stop, req_l1, req_l2, req_storm, req_clean,
           worktime,
    output mode, suspend, clean_worktime_yet, countdown, remind_clean,
           storm_used
  );
endinterface

// File: rtl/hood_countdown.sv
// hood_countdown
// 8-bit seconds countdown shared by the storm and self-clean modes.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val (wins over tick)
//   load_val    value loaded on load
//   tick        1 Hz enable; decrements a non-zero count
//   abort       clear to 0 (wins over load and tick)
//   count       registered remaining seconds
//   done        combinational: this tick takes the count from 1 to 0
module hood_countdown (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  input  logic       abort,
  output logic [7:0] count,
  output logic       done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (abort) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // Only meaningful when the owner is neither loading nor aborting this cycle.
  assign done = tick && (count == 8'd1);

endmodule

// File: rtl/hood_mode_sequencer.sv
// hood_mode_sequencer
// Top-level mode controller for the range-hood fan. Arbitrates user requests
// (stop > clean > storm > l2 > l1, illegal requests dropped), owns the shared
// countdown, drives the worktime accumulator controls and raises the
// cleaning reminder.
// Ports:
//   clkout  system clock
//   rst     asynchronous active-low reset
//   bus     hood_mode_sequencer_if.slave (requests in, status out)
// Build option: HOOD_STORM_ONCE_EN - when defined, storm may be entered only
// once per power session (req_storm dropped while storm_used is set).
// The FSM state is visible directly as bus.mode.
module hood_mode_sequencer
  import hood_mode_sequencer_pkg::*;
#(
  parameter logic [7:0] STORM_SEC    = STORM_SEC_DEF,
  parameter logic [7:0] CLEAN_SEC    = CLEAN_SEC_DEF,
  parameter logic [7:0] REMIND_HOURS = REMIND_HOURS_DEF
) (
  input logic                  clkout,
  input logic                  rst,
  hood_mode_sequencer_if.slave bus
);

  logic [2:0] mode_q, mode_n;
  logic       suspend_q;
  logic       pulse_q, pulse_n;
  logic       remind_q, remind_n;
  logic       used_q, used_n;
  logic       storm_ok;
  logic       cd_load, cd_abort, cd_done;
  logic [7:0] cd_val, cd_count;
  logic [7:0] hours;
  logic       unused_worktime;

  assign hours           = bus.worktime[23:16];
  assign unused_worktime = ^bus.worktime[15:0];

`ifdef HOOD_STORM_ONCE_EN
  assign storm_ok = bus.req_storm && !used_q;
`else
  assign storm_ok = bus.req_storm;
`endif

  hood_countdown u_countdown (
    .clk      (clkout),
    .rst_n    (rst),
    .load     (cd_load),
    .load_val (cd_val),
    .tick     (bus.tick_1s),
    .abort    (cd_abort),
    .count    (cd_count),
    .done     (cd_done)
  );

  always_comb begin
    mode_n   = mode_q;
    cd_load  = 1'b0;
    cd_val   = 8'd0;
    cd_abort = 1'b0;
    pulse_n  = 1'b0;
    used_n   = used_q;
    if (!bus.power_on) begin
      mode_n   = MODE_OFF;
      cd_abort = 1'b1;
      used_n   = 1'b0;
    end else begin
      case (mode_q)
        MODE_OFF: mode_n = MODE_STANDBY;
        MODE_STANDBY: begin
          // A stop here is legal but already satisfied; it still masks
          // the lower-priority requests.
          if (!bus.req_stop) begin
            if (bus.req_clean) begin
              mode_n  = MODE_CLEAN;
              cd_load = 1'b1;
              cd_val  = CLEAN_SEC;
            end else if (storm_ok) begin
              mode_n  = MODE_STORM;
              cd_load = 1'b1;
              cd_val  = STORM_SEC;
              used_n  = 1'b1;
            end else if (bus.req_l2) begin
              mode_n = MODE_L2;
            end else if (bus.req_l1) begin
              mode_n = MODE_L1;
            end
          end
        end
        MODE_L1, MODE_L2: begin
          // Clean is not accepted while the fan is running.
          if (bus.req_stop) begin
            mode_n = MODE_STANDBY;
          end else if (storm_ok) begin
            mode_n  = MODE_STORM;
            cd_load = 1'b1;
            cd_val  = STORM_SEC;
            used_n  = 1'b1;
          end else if (bus.req_l2) begin
            mode_n = MODE_L2;
          end else if (bus.req_l1) begin
            mode_n = MODE_L1;
          end
        end
        MODE_STORM: begin
          if (bus.req_stop) begin
            mode_n   = MODE_STANDBY;
            cd_abort = 1'b1;
          end else if (bus.req_l2) begin
            mode_n   = MODE_L2;
            cd_abort = 1'b1;
          end else if (bus.req_l1) begin
            mode_n   = MODE_L1;
            cd_abort = 1'b1;
          end else if (cd_done) begin
            mode_n = MODE_L2;
          end
        end
        MODE_CLEAN: begin
          if (bus.req_stop) begin
            mode_n   = MODE_STANDBY;
            cd_abort = 1'b1;
          end else if (cd_done) begin
            mode_n  = MODE_STANDBY;
            pulse_n = 1'b1;
          end
        end
        default: mode_n = MODE_OFF;
      endcase
    end
    // Hold the reminder low while the clear pulse is out and one cycle
    // after, so the accumulator's cleared worktime has time to arrive.
    remind_n = (hours >= REMIND_HOURS) && !pulse_n && !pulse_q;
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_OFF;
      suspend_q <= 1'b0;
      pulse_q   <= 1'b0;
      remind_q  <= 1'b0;
      used_q    <= 1'b0;
    end else begin
      mode_q    <= mode_n;
      suspend_q <= fan_running(mode_n);
      pulse_q   <= pulse_n;
      remind_q  <= remind_n;
      used_q    <= used_n;
    end
  end

  assign bus.mode               = mode_q;
  assign bus.suspend            = suspend_q;
  assign bus.clean_worktime_yet = pulse_q;
  assign bus.countdown          = cd_count;
  assign bus.remind_clean       = remind_q;
  assign bus.storm_used         = used_q;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// tb_hood_mode_sequencer
// Directed walk through the main mode scenarios followed by randomized
// request traffic, every cycle compared against a behavioural model.
module tb_hood_mode_sequencer;

  localparam int STORM_S = 60;
  localparam int CLEAN_S = 180;
  localparam int REMIND_H = 10;  // decimal hours

  logic clkout;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hood_mode_sequencer_if bus ();

  hood_mode_sequencer dut (
    .clkout (clkout),
    .rst    (rst),
    .bus    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clkout = 1'b0;
  always #5 clkout = ~clkout;

  // ---------------- reference model ----------------
  int m_mode, m_cd;
  bit m_used, m_pulse, m_remind, m_susp;

  function automatic int bcd_to_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cd = 0; m_used = 0; m_pulse = 0; m_remind = 0; m_susp = 0;
  endtask

  // Request list in priority order: stop, clean, storm, l2, l1.
  task automatic model_step();
    int  nm, ncd, pick;
    bit  np;
    bit  req[5];
    bit  legal[5];
    bit  once;
    once = 0;
`ifdef HOOD_STORM_ONCE_EN
    once = 1;
`endif
    nm = m_mode; ncd = m_cd; np = 0; pick = -1;
    req[0] = bus.req_stop;  req[1] = bus.req_clean; req[2] = bus.req_storm;
    req[3] = bus.req_l2;    req[4] = bus.req_l1;
    legal[0] = m_mode inside {1, 2, 3, 4, 5};
    legal[1] = (m_mode == 1);
    legal[2] = (m_mode inside {1, 2, 3}) && !(once && m_used);
    legal[3] = m_mode inside {1, 2, 3, 4};
    legal[4] = legal[3];
    if (!bus.power_on) begin
      nm = 0; ncd = 0; m_used = 0;
    end else if (m_mode == 0) begin
      nm = 1;
    end else begin
      for (int i = 4; i >= 0; i--) if (req[i] && legal[i]) pick = i;
      case (pick)
        0: begin nm = 1; ncd = 0; end
        1: begin nm = 5; ncd = CLEAN_S; end
        2: begin nm = 4; ncd = STORM_S; m_used = 1; end
        3: begin nm = 3; ncd = 0; end
        4: begin nm = 2; ncd = 0; end
        default: begin
          if (bus.tick_1s && m_cd > 0) begin
            ncd = m_cd - 1;
            if (ncd == 0 && m_mode == 4) nm = 3;
            if (ncd == 0 && m_mode == 5) begin nm = 1; np = 1; end
          end
        end
      endcase
    end
    m_remind = (bcd_to_int(bus.worktime[23:16]) >= REMIND_H) && !np && !m_pulse;
    m_pulse  = np;
    m_mode   = nm;
    m_cd     = ncd;
    m_susp   = nm inside {2, 3, 4};
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("mode",      int'(bus.mode),               m_mode);
    check_val("countdown", int'(bus.countdown),          m_cd);
    check_val("suspend",   int'(bus.suspend),            int'(m_susp));
    check_val("clean_pls", int'(bus.clean_worktime_yet), int'(m_pulse));
    check_val("remind",    int'(bus.remind_clean),       int'(m_remind));
    check_val("storm_used",int'(bus.storm_used),         int'(m_used));
  endtask

  // ---------------- driver ----------------
  // r = {stop, clean, storm, l2, l1}
  task automatic cycle(input logic t, input logic [4:0] r);
    bus.tick_1s = t;
    {bus.req_stop, bus.req_clean, bus.req_storm, bus.req_l2, bus.req_l1} = r;
    @(posedge clkout);
    model_step();
    @(negedge clkout);
    check_all();
    bus.tick_1s = 1'b0;
    {bus.req_stop, bus.req_clean, bus.req_storm, bus.req_l2, bus.req_l1} = 5'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 5'b0);
  endtask

  localparam logic [4:0] R_STOP = 5'b10000, R_CLEAN = 5'b01000,
                         R_STORM = 5'b00100, R_L2 = 5'b00010, R_L1 = 5'b00001;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    bus.power_on = 1'b0; bus.tick_1s = 1'b0; bus.worktime = 24'h0;
    {bus.req_stop, bus.req_clean, bus.req_storm, bus.req_l2, bus.req_l1} = 5'b0;
    model_reset();
    repeat (2) @(posedge clkout);
    @(negedge clkout);
    check_all();
    rst = 1'b1;
    bus.power_on = 1'b1;

    // power up to standby
    cycle(1'b0, 5'b0);
    check_val("standby_after_pwr", int'(bus.mode), 1);
    // l1 and storm together: storm wins, tick ignored on entry
    cycle(1'b1, R_L1 | R_STORM);
    check_val("storm_load", int'(bus.countdown), 60);
    ticks(59);
    check_val("storm_cd1", int'(bus.countdown), 1);
    ticks(1);
    check_val("storm_to_l2", int'(bus.mode), 3);

    // reminder and self-clean
    cycle(1'b0, R_STOP);
    bus.worktime = 24'h100000;
    cycle(1'b0, 5'b0);
    check_val("remind_on", int'(bus.remind_clean), 1);
    cycle(1'b1, R_CLEAN | R_L2);
    check_val("clean_load", int'(bus.countdown), 180);
    ticks(180);
    check_val("clean_pulse", int'(bus.clean_worktime_yet), 1);
    check_val("clean_remind_lo", int'(bus.remind_clean), 0);
    cycle(1'b0, 5'b0);
    bus.worktime = 24'h000012;
    cycle(1'b0, 5'b0);
    cycle(1'b0, 5'b0);

    // clean aborted at 50
    cycle(1'b0, R_CLEAN);
    ticks(130);
    check_val("clean_cd50", int'(bus.countdown), 50);
    cycle(1'b0, R_STOP);
    check_val("clean_abort_mode", int'(bus.mode), 1);

    // l2, storm, power off mid-countdown
    cycle(1'b0, R_L2);
    cycle(1'b0, R_STORM);
    ticks(30);
    check_val("storm_cd30", int'(bus.countdown), 30);
    bus.power_on = 1'b0;
    cycle(1'b0, R_L1);
    check_val("pwr_off_mode", int'(bus.mode), 0);
    bus.power_on = 1'b1;
    cycle(1'b0, 5'b0);

    // storm twice in one session
    cycle(1'b0, R_STORM);
    ticks(60);
    cycle(1'b0, R_STORM);
`ifdef HOOD_STORM_ONCE_EN
    check_val("storm_again", int'(bus.mode), 3);
`else
    check_val("storm_again", int'(bus.mode), 4);
`endif

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [4:0] r;
      r = 5'b0;
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 39) == 0) r[b] = 1'b1;
      if ($urandom_range(0, 199) == 0) bus.power_on = ~bus.power_on;
      if (!bus.power_on && $urandom_range(0, 9) == 0) bus.power_on = 1'b1;
      if ($urandom_range(0, 149) == 0)
        bus.worktime = {int_to_bcd($urandom_range(0, 24)),
                        int_to_bcd($urandom_range(0, 59)),
                        int_to_bcd($urandom_range(0, 59))};
      cycle(logic'($urandom_range(0, 3) != 0), r);
    end

    // asynchronous reset in the middle of a clean countdown
    bus.power_on = 1'b1;
    cycle(1'b0, R_STOP);
    cycle(1'b0, R_CLEAN);
    ticks(20);
    @(posedge clkout);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clkout);
    check_all();
    rst = 1'b1;
    cycle(1'b0, 5'b0);
    check_val("post_reset_standby", int'(bus.mode), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
